// File: rtl/alu_operand_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_arbiter_if
// Description : Bundle of every non-clock signal of alu_operand_arbiter:
//               two requester ports (valid/ready with op, A, reg, imm,
//               imm_sel), the registered ALU operand bus with its start
//               pulse and result return, and the response channel.
//               slave  - seen by the arbiter
//               master - seen by the requesters / ALU / response consumer
// Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 4
);
    // requester 0 (instruction pipeline)
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [OP_W-1:0]   i_req0_op;
    logic [DATA_W-1:0] i_req0_a;
    logic [DATA_W-1:0] i_req0_reg;
    logic [DATA_W-1:0] i_req0_imm;
    logic              i_req0_imm_sel;
    // requester 1 (feedback/timing unit)
    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [OP_W-1:0]   i_req1_op;
    logic [DATA_W-1:0] i_req1_a;
    logic [DATA_W-1:0] i_req1_reg;
    logic [DATA_W-1:0] i_req1_imm;
    logic              i_req1_imm_sel;
    // ALU side
    logic [OP_W-1:0]   o_alu_op;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_reg;
    logic [DATA_W-1:0] o_alu_imm;
    logic              o_alu_imm_sel;
    logic              o_alu_start;
    logic [DATA_W-1:0] i_alu_result;
    // response channel
    logic              o_rsp_valid;
    logic              o_rsp_id;
    logic [DATA_W-1:0] o_rsp_data;
    logic              i_rsp_ready;

    modport slave (
        input  i_req0_valid, i_req0_op, i_req0_a, i_req0_reg, i_req0_imm, i_req0_imm_sel,
        input  i_req1_valid, i_req1_op, i_req1_a, i_req1_reg, i_req1_imm, i_req1_imm_sel,
        input  i_alu_result, i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_alu_op, o_alu_a, o_alu_reg, o_alu_imm, o_alu_imm_sel, o_alu_start,
        output o_rsp_valid, o_rsp_id, o_rsp_data
    );

    modport master (
        output i_req0_valid, i_req0_op, i_req0_a, i_req0_reg, i_req0_imm, i_req0_imm_sel,
        output i_req1_valid, i_req1_op, i_req1_a, i_req1_reg, i_req1_imm, i_req1_imm_sel,
        output i_alu_result, i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_alu_op, o_alu_a, o_alu_reg, o_alu_imm, o_alu_imm_sel, o_alu_start,
        input  o_rsp_valid, o_rsp_id, o_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_arbiter
// Description : Shares one ALU (and its operand-B imm/reg mux) between the
//               instruction pipeline (port 0) and the feedback/timing unit
//               (port 1). One operation at a time: accept, drive the latched
//               operands for ALU_LAT cycles, capture the result, then hold
//               it on the response channel until the consumer takes it.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous, active-high reset
//               bus  - alu_operand_arbiter_if.slave (requesters, ALU operand
//                      bus / result, response channel)
// Parameters  : DATA_W  operand/result width
//               OP_W    opcode width
//               ALU_LAT issue-to-result latency, legal 1..15
// Config      : `define ALU_ARB_FIXED_PRIO_EN -> port 0 always wins a tie
//               (no last-grant pointer). Default is round-robin.
// Revision    : 1.0  initial release
// ============================================================================
module alu_operand_arbiter #(
    parameter int DATA_W  = 64,
    parameter int OP_W    = 4,
    parameter int ALU_LAT = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_operand_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              winner;

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_imm;
    logic              alu_imm_sel;
    logic              alu_start;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant0 = bus.i_req0_valid;
    assign grant1 = bus.i_req1_valid & ~bus.i_req0_valid;
`else
    // last_grant holds the index of the most recent winner; on a tie the
    // other port goes next. Reset to 1 so port 0 takes the first tie.
    logic last_grant;

    assign grant0 = bus.i_req0_valid & (~bus.i_req1_valid |  last_grant);
    assign grant1 = bus.i_req1_valid & (~bus.i_req0_valid | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= winner;
        end
    end
`endif

    // Readies are masked by rst so nothing can be accepted on a reset edge.
    assign bus.o_req0_ready = ~rst & (state == IDLE) & grant0;
    assign bus.o_req1_ready = ~rst & (state == IDLE) & grant1;
    assign accept           = bus.o_req0_ready | bus.o_req1_ready;
    assign winner           = bus.o_req1_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)          state_next = EXEC;
            EXEC:    if (cnt == 4'd1)     state_next = RESP;
            RESP:    if (bus.i_rsp_ready) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, latency counter, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op      <= '0;
            alu_a       <= '0;
            alu_reg     <= '0;
            alu_imm     <= '0;
            alu_imm_sel <= 1'b0;
            alu_start   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            cnt         <= 4'd0;
        end else begin
            alu_start <= accept;
            if (accept) begin
                // operands stay put until the next accept, even after the
                // result has been returned
                alu_op      <= winner ? bus.i_req1_op      : bus.i_req0_op;
                alu_a       <= winner ? bus.i_req1_a       : bus.i_req0_a;
                alu_reg     <= winner ? bus.i_req1_reg     : bus.i_req0_reg;
                alu_imm     <= winner ? bus.i_req1_imm     : bus.i_req0_imm;
                alu_imm_sel <= winner ? bus.i_req1_imm_sel : bus.i_req0_imm_sel;
                rsp_id      <= winner;
                cnt         <= LAT_INIT;
            end
            if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                // the ALU result is valid on the edge the counter leaves 1
                if (cnt == 4'd1) begin
                    rsp_data <= bus.i_alu_result;
                end
            end
        end
    end

    assign bus.o_alu_op      = alu_op;
    assign bus.o_alu_a       = alu_a;
    assign bus.o_alu_reg     = alu_reg;
    assign bus.o_alu_imm     = alu_imm;
    assign bus.o_alu_imm_sel = alu_imm_sel;
    assign bus.o_alu_start   = alu_start;
    assign bus.o_rsp_valid   = (state == RESP);
    assign bus.o_rsp_id      = rsp_id;
    assign bus.o_rsp_data    = rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_arbiter
// Description : Self-checking bench for alu_operand_arbiter. A transaction
//               level model (time since accept, pending response, last
//               winner) predicts every output each cycle; directed scenarios
//               pin the model with literal values; a random phase follows.
//               A small ALU model returns the true result only in the cycle
//               it is due, and the complement otherwise.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_operand_arbiter;
    localparam int DW = 64;
    localparam int OW = 4;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_operand_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus ();

    alu_operand_arbiter #(.DATA_W(DW), .OP_W(OW), .ALU_LAT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_id[$];
    int acc_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        case (op)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a & b;
            4'd3:    alu_f = a | b;
            4'd4:    alu_f = a ^ b;
            4'd5:    alu_f = a << b[5:0];
            default: alu_f = ~a + b;
        endcase
    endfunction

    // ---------------- ALU model: result due ALU_LAT edges after start ----
    int          age = 100;
    int          cur_age;
    logic [63:0] alu_true;
    always @(posedge clk) begin
        if (bus.o_alu_start) age <= 1;
        else if (age < 100)  age <= age + 1;
    end
    always_comb begin
        alu_true = alu_f(bus.o_alu_op, bus.o_alu_a,
                         bus.o_alu_imm_sel ? bus.o_alu_imm : bus.o_alu_reg);
        cur_age  = bus.o_alu_start ? 0 : age;
        bus.i_alu_result = (cur_age == L - 1) ? alu_true : ~alu_true;
    end

    // ---------------- transaction model + per-cycle compare --------------
    int          m_since = -1;     // edges since accept, -1 = nothing in flight
    logic        m_last  = 1'b1;
    logic [3:0]  m_op    = '0;
    logic [63:0] m_a     = '0;
    logic [63:0] m_reg   = '0;
    logic [63:0] m_imm   = '0;
    logic        m_sel   = 1'b0;
    logic        m_id    = 1'b0;
    logic [63:0] m_res   = '0;

    initial begin : compare
        logic e0, e1, rv, v0, v1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            v0 = bus.i_req0_valid;
            v1 = bus.i_req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
            e0 = v0;
            e1 = v1 && !v0;
`else
            e0 = v0 && (!v1 || m_last);
            e1 = v1 && (!v0 || !m_last);
`endif
            e0 = e0 && (m_since < 0) && !rst;
            e1 = e1 && (m_since < 0) && !rst;
            rv = (m_since >= L + 1);
            chk("ready0",    bus.o_req0_ready,  e0);
            chk("ready1",    bus.o_req1_ready,  e1);
            chk("alu_start", bus.o_alu_start,   m_since == 1);
            chk("rsp_valid", bus.o_rsp_valid,   rv);
            chk("alu_op",    bus.o_alu_op,      m_op);
            chk("alu_a",     bus.o_alu_a,       m_a);
            chk("alu_reg",   bus.o_alu_reg,     m_reg);
            chk("alu_imm",   bus.o_alu_imm,     m_imm);
            chk("alu_sel",   bus.o_alu_imm_sel, m_sel);
            if (rv) begin
                chk("rsp_id",   bus.o_rsp_id,   m_id);
                chk("rsp_data", bus.o_rsp_data, m_res);
            end
            if (bus.i_req0_valid && bus.o_req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
            if (bus.i_req1_valid && bus.o_req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
            // advance the model across the coming edge
            if (rst) begin
                m_since = -1; m_last = 1'b1; m_op = '0; m_a = '0; m_reg = '0;
                m_imm = '0; m_sel = 1'b0; m_id = 1'b0;
            end else if (e0 || e1) begin
                m_op    = e1 ? bus.i_req1_op      : bus.i_req0_op;
                m_a     = e1 ? bus.i_req1_a       : bus.i_req0_a;
                m_reg   = e1 ? bus.i_req1_reg     : bus.i_req0_reg;
                m_imm   = e1 ? bus.i_req1_imm     : bus.i_req0_imm;
                m_sel   = e1 ? bus.i_req1_imm_sel : bus.i_req0_imm_sel;
                m_id    = e1;
                m_last  = e1;
                m_res   = alu_f(m_op, m_a, m_sel ? m_imm : m_reg);
                m_since = 1;
            end else if (m_since >= 0) begin
                if (m_since >= L + 1) begin
                    if (bus.i_rsp_ready) m_since = -1;
                end else begin
                    m_since++;
                end
            end
        end
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic [3:0] op, input logic [63:0] a, input logic [63:0] r,
                            input logic [63:0] imm, input logic sel);
        bus.i_req0_op = op; bus.i_req0_a = a; bus.i_req0_reg = r;
        bus.i_req0_imm = imm; bus.i_req0_imm_sel = sel;
    endtask

    task automatic set_req1(input logic [3:0] op, input logic [63:0] a, input logic [63:0] r,
                            input logic [63:0] imm, input logic sel);
        bus.i_req1_op = op; bus.i_req1_a = a; bus.i_req1_reg = r;
        bus.i_req1_imm = imm; bus.i_req1_imm_sel = sel;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // waits (at negedges) until the given port is ready; caller then step()s
    task automatic wait_accept(input int port, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((port == 0) ? bus.o_req0_ready : bus.o_req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_accept_timeout"}, got, 1'b1);
    endtask

    task automatic wait_rsp(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.o_rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_rsp_timeout"}, got, 1'b1);
    endtask

    // ---------------- main sequence --------------------------------------
    initial begin : main
        logic [63:0] ones;
        ones = '1;
        bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0; bus.i_rsp_ready = 1'b1;
        set_req0(4'd0, '0, '0, '0, 1'b0);
        set_req1(4'd0, '0, '0, '0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_alu_op",   bus.o_alu_op,      0);
        chk("rst_alu_a",    bus.o_alu_a,       0);
        chk("rst_alu_sel",  bus.o_alu_imm_sel, 0);
        chk("rst_start",    bus.o_alu_start,   0);
        chk("rst_rsp_val",  bus.o_rsp_valid,   0);
        chk("rst_rsp_id",   bus.o_rsp_id,      0);
        chk("rst_rsp_data", bus.o_rsp_data,    0);

        // single request: ADD 5 + imm 7
        step();
        set_req0(4'd0, 64'd5, 64'hDEAD, 64'd7, 1'b1);
        bus.i_req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready0", bus.o_req0_ready, 1);
        step();
        bus.i_req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_start",   bus.o_alu_start,   1);
        chk("t1_imm_sel", bus.o_alu_imm_sel, 1);
        chk("t1_imm",     bus.o_alu_imm,     7);
        @(negedge clk);
        chk("t1_start_off", bus.o_alu_start, 0);
        chk("t1_rsp_early", bus.o_rsp_valid, 0);
        repeat (L - 2) @(negedge clk);
        @(negedge clk);
        chk("t1_rsp_valid", bus.o_rsp_valid, 1);
        chk("t1_rsp_id",    bus.o_rsp_id,    0);
        chk("t1_rsp_data",  bus.o_rsp_data,  12);
        step();
        @(negedge clk);
        chk("t1_rsp_drop", bus.o_rsp_valid, 0);

        // register operand from port 1: XOR with all ones
        step();
        set_req1(4'd4, 64'h0123_4567_89AB_CDEF, ones, 64'h55, 1'b0);
        bus.i_req1_valid = 1'b1;
        wait_accept(1, "t2");
        step();
        bus.i_req1_valid = 1'b0;
        @(negedge clk);
        chk("t2_imm_sel", bus.o_alu_imm_sel, 0);
        chk("t2_reg",     bus.o_alu_reg,     ones);
        wait_rsp("t2");
        chk("t2_rsp_id",   bus.o_rsp_id,   1);
        chk("t2_rsp_data", bus.o_rsp_data, 64'hFEDC_BA98_7654_3210);
        step();

        // tie, both held valid for several operations
        do_reset();
        acc_id.delete();
        acc_cyc.delete();
        set_req0(4'd0, 64'd10, 64'd1, 64'd2, 1'b0);
        set_req1(4'd1, 64'd20, 64'd3, 64'd4, 1'b1);
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        repeat (4 * (L + 2) + 2) step();
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        chk("tie_count", acc_id.size() >= 4, 1);
        if (acc_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                chk($sformatf("tie_order%0d", i), acc_id[i], 0);
`else
                chk($sformatf("tie_order%0d", i), acc_id[i], i % 2);
`endif
            end
            for (int i = 0; i < 3; i++)
                chk($sformatf("tie_spacing%0d", i), acc_cyc[i+1] - acc_cyc[i], L + 2);
        end

        // response backpressure: SUB 100 - reg 58 = 42
        repeat (L + 4) step();
        bus.i_rsp_ready = 1'b0;
        set_req0(4'd1, 64'd100, 64'd58, 64'd9, 1'b0);
        bus.i_req0_valid = 1'b1;
        wait_accept(0, "bp");
        step();
        bus.i_req1_valid = 1'b1;
        wait_rsp("bp");
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid",  bus.o_rsp_valid,  1);
            chk("bp_id",     bus.o_rsp_id,     0);
            chk("bp_data",   bus.o_rsp_data,   42);
            chk("bp_ready0", bus.o_req0_ready, 0);
            chk("bp_ready1", bus.o_req1_ready, 0);
        end
        step();
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_valid", bus.o_rsp_valid, 1);
        @(negedge clk);
        chk("bp_rsp_drop",    bus.o_rsp_valid,  0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("bp_idle_ready0", bus.o_req0_ready, 1);
`else
        chk("bp_idle_ready1", bus.o_req1_ready, 1);
`endif
        step();
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;

        // reset mid-EXEC
        repeat (L + 4) step();
        set_req0(4'd2, 64'hF0F0, 64'h0FF0, 64'h1234, 1'b1);
        bus.i_req0_valid = 1'b1;
        wait_accept(0, "rx");
        step();
        rst = 1'b1;
        bus.i_req0_valid = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rx_alu_op",   bus.o_alu_op,      0);
        chk("rx_alu_a",    bus.o_alu_a,       0);
        chk("rx_alu_reg",  bus.o_alu_reg,     0);
        chk("rx_alu_imm",  bus.o_alu_imm,     0);
        chk("rx_alu_sel",  bus.o_alu_imm_sel, 0);
        chk("rx_start",    bus.o_alu_start,   0);
        chk("rx_rsp_id",   bus.o_rsp_id,      0);
        chk("rx_rsp_data", bus.o_rsp_data,    0);
        repeat (L + 6) begin
            @(negedge clk);
            chk("rx_no_rsp", bus.o_rsp_valid, 0);
        end
        step();
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        @(negedge clk);
        chk("rx_tie_ready0", bus.o_req0_ready, 1);
        chk("rx_tie_ready1", bus.o_req1_ready, 0);

        // random traffic, checked every cycle by the compare process
        for (int n = 0; n < 800; n++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
            bus.i_req0_valid = ($urandom_range(0, 9) < 6);
            bus.i_req1_valid = ($urandom_range(0, 9) < 6);
            bus.i_rsp_ready  = ($urandom_range(0, 9) < 7);
            set_req0(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            set_req1(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        step();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
